// File: rtl/phy_tx_arbiter.sv
// Packet-granular 2:1 AXI-Stream arbiter feeding the 64B/66B TX framer, with a
// programmable inter-packet gap. Define PHY_TX_ARB_STRICT_PRIO_EN for a fixed port-0 tie-break.
module phy_tx_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned IFG_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     s0_axis_data,
  input  logic [DATA_W/8-1:0]   s0_axis_keep,
  input  logic                  s0_axis_last,
  input  logic                  s0_axis_valid,
  output logic                  s0_axis_ready,
  input  logic [DATA_W-1:0]     s1_axis_data,
  input  logic [DATA_W/8-1:0]   s1_axis_keep,
  input  logic                  s1_axis_last,
  input  logic                  s1_axis_valid,
  output logic                  s1_axis_ready,
  output logic [DATA_W-1:0]     m_axis_data,
  output logic [DATA_W/8-1:0]   m_axis_keep,
  output logic                  m_axis_last,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [1:0]            o_grant,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_pkt_cnt0,
  output logic [CNT_W-1:0]      o_pkt_cnt1
);

  localparam int unsigned GAP_W = $clog2(IFG_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               ptr_q, ptr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;
  logic               pick1;

  // ptr_q holds the last-served port; on a tie the other one wins.
  always_comb begin
`ifdef PHY_TX_ARB_STRICT_PRIO_EN
    pick1 = s1_axis_valid && !s0_axis_valid;
`else
    pick1 = s1_axis_valid && (!s0_axis_valid || !ptr_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: begin
        if ((s0_axis_valid || s1_axis_valid) && m_axis_ready)
          state_d = pick1 ? GNT1 : GNT0;
      end
      GNT0: begin
        if (s0_axis_valid && m_axis_ready && s0_axis_last) begin
          state_d = GAP;
          gap_d   = GAP_W'(IFG_CYCLES);
          cnt0_d  = cnt0_q + CNT_W'(1);
          ptr_d   = 1'b0;
        end
      end
      GNT1: begin
        if (s1_axis_valid && m_axis_ready && s1_axis_last) begin
          state_d = GAP;
          gap_d   = GAP_W'(IFG_CYCLES);
          cnt1_d  = cnt1_q + CNT_W'(1);
          ptr_d   = 1'b1;
        end
      end
      default: begin
        // Leaving on a count of 1 (or 0) gives max(IFG_CYCLES,1) gap cycles.
        if (gap_q <= GAP_W'(1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
    endcase
    grant_d = {state_d == GNT1, state_d == GNT0};
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= 1'b1;
      gap_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    m_axis_data   = '0;
    m_axis_keep   = '0;
    m_axis_last   = 1'b0;
    m_axis_valid  = 1'b0;
    s0_axis_ready = 1'b0;
    s1_axis_ready = 1'b0;
    case (state_q)
      GNT0: begin
        m_axis_data   = s0_axis_data;
        m_axis_keep   = s0_axis_keep;
        m_axis_last   = s0_axis_last;
        m_axis_valid  = s0_axis_valid;
        s0_axis_ready = m_axis_ready;
      end
      GNT1: begin
        m_axis_data   = s1_axis_data;
        m_axis_keep   = s1_axis_keep;
        m_axis_last   = s1_axis_last;
        m_axis_valid  = s1_axis_valid;
        s1_axis_ready = m_axis_ready;
      end
      default: ;
    endcase
  end

  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_pkt_cnt0 = cnt0_q;
  assign o_pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Bench for phy_tx_arbiter: directed vector table, reset/wrap sequences and
// randomized traffic against a cycle-level reference model.
module tb_phy_tx_arbiter;
  localparam int unsigned DW  = 64;
  localparam int unsigned KW  = DW / 8;
  localparam int unsigned IFG = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned IFG_EFF = (IFG == 0) ? 1 : IFG;
`ifdef PHY_TX_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] s0_axis_data, s1_axis_data, m_axis_data;
  logic [KW-1:0] s0_axis_keep, s1_axis_keep, m_axis_keep;
  logic          s0_axis_last, s0_axis_valid, s0_axis_ready;
  logic          s1_axis_last, s1_axis_valid, s1_axis_ready;
  logic          m_axis_last, m_axis_valid, m_axis_ready;
  logic [1:0]    o_grant;
  logic          o_busy;
  logic [CW-1:0] o_pkt_cnt0, o_pkt_cnt1;

  always #5 clk = ~clk;

  phy_tx_arbiter #(.DATA_W(DW), .IFG_CYCLES(IFG), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .s0_axis_data(s0_axis_data), .s0_axis_keep(s0_axis_keep), .s0_axis_last(s0_axis_last),
    .s0_axis_valid(s0_axis_valid), .s0_axis_ready(s0_axis_ready),
    .s1_axis_data(s1_axis_data), .s1_axis_keep(s1_axis_keep), .s1_axis_last(s1_axis_last),
    .s1_axis_valid(s1_axis_valid), .s1_axis_ready(s1_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_keep(m_axis_keep), .m_axis_last(m_axis_last),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .o_grant(o_grant), .o_busy(o_busy), .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, expected event never seen", name);
  endtask

  // Directed vectors: inputs for one cycle plus the owner/busy expected in that cycle.
  typedef struct {
    bit v0, l0, v1, l1, mr;
    logic [7:0] k;
    logic [1:0] eg;
    bit eb;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit v0, bit l0, bit v1, bit l1, bit mr,
                              logic [7:0] k, logic [1:0] eg, bit eb);
    vec_t v;
    v.v0 = v0; v.l0 = l0; v.v1 = v1; v.l1 = l1; v.mr = mr; v.k = k; v.eg = eg; v.eb = eb;
    return v;
  endfunction

  // Reference model and traffic source state.
  int          own, gap, ptr;
  logic [CW-1:0] mcnt[2];
  logic [55:0] eseq[2], sseq[2];
  int          sbeat[2], slen[2];
  int          vpct[2], rpct, flen;
  bit          sv[2], sl[2], mr;
  logic [7:0]  sk[2];
  logic [63:0] sd[2];
  logic [1:0]  pg;
  int          gq[$];

  function automatic int new_len();
    return (flen != 0) ? flen : int'($urandom_range(4, 1));
  endfunction

  task automatic reset_all();
    i_rst = 1'b1;
    s0_axis_valid = 0; s1_axis_valid = 0; s0_axis_last = 0; s1_axis_last = 0;
    s0_axis_data = '0; s1_axis_data = '0; s0_axis_keep = '0; s1_axis_keep = '0;
    m_axis_ready = 0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    own = 2; gap = 0; ptr = 1; pg = 2'b00;
    for (int p = 0; p < 2; p++) begin
      mcnt[p] = '0; eseq[p] = '0; sseq[p] = '0; sbeat[p] = 0; slen[p] = new_len();
    end
  endtask

  task automatic step();
    logic [1:0] eg;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      sl[p] = (sbeat[p] == slen[p] - 1);
      sv[p] = (int'($urandom_range(99, 0)) < vpct[p]);
      sk[p] = 8'($urandom);
      sd[p] = {(p == 0) ? 8'hA0 : 8'hB1, sseq[p]};
    end
    mr = (int'($urandom_range(99, 0)) < rpct);
    s0_axis_valid = sv[0]; s0_axis_last = sl[0]; s0_axis_keep = sk[0]; s0_axis_data = sd[0];
    s1_axis_valid = sv[1]; s1_axis_last = sl[1]; s1_axis_keep = sk[1]; s1_axis_data = sd[1];
    m_axis_ready = mr;
    @(negedge clk);
    eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    chk("grant", o_grant, eg);
    chk("busy", o_busy, (own != 2) || (gap > 0));
    chk("s0_ready", s0_axis_ready, (own == 0) && mr);
    chk("s1_ready", s1_axis_ready, (own == 1) && mr);
    if (own != 2) begin
      chk("m_valid", m_axis_valid, sv[own]);
      chk("m_data", m_axis_data, {(own == 0) ? 8'hA0 : 8'hB1, eseq[own]});
      chk("m_last", m_axis_last, sl[own]);
      chk("m_keep", m_axis_keep, sk[own]);
    end else begin
      chk("m_valid_idle", m_axis_valid, 0);
      chk("m_data_idle", m_axis_data, 0);
      chk("m_keep_idle", {m_axis_keep, m_axis_last}, 0);
    end
    chk("cnt0", o_pkt_cnt0, mcnt[0]);
    chk("cnt1", o_pkt_cnt1, mcnt[1]);
    if (pg == 2'b00 && o_grant != 2'b00) gq.push_back((o_grant == 2'b10) ? 1 : 0);
    pg = o_grant;
    // Source follows the real handshake; the model follows its own idea of ready.
    if (s0_axis_valid && s0_axis_ready) begin
      sseq[0]++;
      if (sl[0]) begin sbeat[0] = 0; slen[0] = new_len(); end else sbeat[0]++;
    end
    if (s1_axis_valid && s1_axis_ready) begin
      sseq[1]++;
      if (sl[1]) begin sbeat[1] = 0; slen[1] = new_len(); end else sbeat[1]++;
    end
    if (own != 2) begin
      if (sv[own] && mr) begin
        eseq[own]++;
        if (sl[own]) begin
          mcnt[own]++; ptr = own; own = 2; gap = IFG_EFF;
        end
      end
    end else if (gap > 0) begin
      gap--;
    end else if (mr && (sv[0] || sv[1])) begin
      own = (sv[0] && sv[1]) ? (STRICT ? 0 : 1 - ptr) : (sv[0] ? 0 : 1);
    end
  endtask

  initial begin
    bit done;
    // Basic 3-beat, back-pressured 2-beat, single-beat keep=80, last-vs-new-valid overlap.
    tbl.push_back(mk(1,0,0,0,1,8'hFF,2'b00,0));
    tbl.push_back(mk(1,0,0,0,1,8'hFF,2'b01,1));
    tbl.push_back(mk(1,0,0,0,1,8'hFF,2'b01,1));
    tbl.push_back(mk(1,1,0,0,1,8'hFF,2'b01,1));
    repeat (4) tbl.push_back(mk(0,0,0,0,1,8'hFF,2'b00,1));
    tbl.push_back(mk(0,0,1,0,0,8'hFF,2'b00,0));
    tbl.push_back(mk(0,0,1,0,0,8'hFF,2'b00,0));
    tbl.push_back(mk(0,0,1,0,1,8'hFF,2'b00,0));
    tbl.push_back(mk(0,0,1,0,1,8'hFF,2'b10,1));
    repeat (5) tbl.push_back(mk(0,0,1,0,0,8'hFF,2'b10,1));
    tbl.push_back(mk(0,0,1,1,1,8'h80,2'b10,1));
    repeat (4) tbl.push_back(mk(0,0,0,0,1,8'hFF,2'b00,1));
    tbl.push_back(mk(0,0,1,1,1,8'h80,2'b00,0));
    tbl.push_back(mk(0,0,1,1,1,8'h80,2'b10,1));
    repeat (4) tbl.push_back(mk(1,0,0,0,1,8'hFF,2'b00,1));
    tbl.push_back(mk(1,0,0,0,1,8'hFF,2'b00,0));
    tbl.push_back(mk(1,1,1,0,1,8'h3F,2'b01,1));
    repeat (4) tbl.push_back(mk(0,0,1,0,1,8'hFF,2'b00,1));
    tbl.push_back(mk(0,0,1,0,1,8'hFF,2'b00,0));
    tbl.push_back(mk(0,0,1,1,1,8'h01,2'b10,1));
    repeat (4) tbl.push_back(mk(0,0,0,0,1,8'hFF,2'b00,1));
    tbl.push_back(mk(0,0,0,0,1,8'hFF,2'b00,0));

    reset_all();
    i_rst = 1'b1;
    #1;
    chk("rst_grant", o_grant, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cnt", {o_pkt_cnt0, o_pkt_cnt1}, 0);
    chk("rst_m_valid", m_axis_valid, 0);
    @(posedge clk); #1 i_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      s0_axis_valid = tbl[i].v0; s0_axis_last = tbl[i].l0; s0_axis_keep = tbl[i].k;
      s1_axis_valid = tbl[i].v1; s1_axis_last = tbl[i].l1; s1_axis_keep = tbl[i].k;
      s0_axis_data = {8'hA0, 56'(i)}; s1_axis_data = {8'hB1, 56'(i)};
      m_axis_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), o_grant, tbl[i].eg);
      chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].eb);
      chk($sformatf("vec%0d_rdy", i), {s1_axis_ready, s0_axis_ready}, tbl[i].eg & {tbl[i].mr, tbl[i].mr});
      chk($sformatf("vec%0d_mvalid", i), m_axis_valid,
          (tbl[i].eg[0] & tbl[i].v0) | (tbl[i].eg[1] & tbl[i].v1));
      chk($sformatf("vec%0d_mlast", i), m_axis_last,
          (tbl[i].eg[0] & tbl[i].l0) | (tbl[i].eg[1] & tbl[i].l1));
      chk($sformatf("vec%0d_mdata", i), m_axis_data,
          tbl[i].eg[0] ? {8'hA0, 56'(i)} : tbl[i].eg[1] ? {8'hB1, 56'(i)} : 64'h0);
      chk($sformatf("vec%0d_mkeep", i), m_axis_keep, (tbl[i].eg != 2'b00) ? tbl[i].k : 8'h00);
    end
    chk("vec_cnt0", o_pkt_cnt0, 2);
    chk("vec_cnt1", o_pkt_cnt1, 3);

    // Reset during beat 2 of a 4-beat packet, then a tie must go to port 0.
    @(posedge clk); #1 s0_axis_valid = 1; s0_axis_last = 0; s1_axis_valid = 0; m_axis_ready = 1;
    @(posedge clk); #1;
    @(negedge clk) chk("mid_beat1_grant", o_grant, 2'b01);
    @(posedge clk); #1;
    @(negedge clk) chk("mid_beat2_valid", m_axis_valid, 1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_grant", o_grant, 0);
    chk("mid_rst_mvalid", m_axis_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_cnt", {o_pkt_cnt0, o_pkt_cnt1}, 0);
    chk("mid_rst_ready", s0_axis_ready, 0);
    @(posedge clk); #1 i_rst = 1'b0; s1_axis_valid = 1; s1_axis_last = 0;
    @(negedge clk) chk("post_rst_idle", o_grant, 0);
    @(posedge clk); #1;
    @(negedge clk) chk("post_rst_tie", o_grant, 2'b01);

    // Both ports saturated with 2-beat packets.
    reset_all();
    vpct[0] = 100; vpct[1] = 100; rpct = 100; flen = 2;
    slen[0] = 2; slen[1] = 2;
    gq.delete();
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      done = (int'(mcnt[0]) + int'(mcnt[1]) >= 4);
    end
    if (!done) fail_bound("contention_4pkts");
    step();
    if (gq.size() < 4) fail_bound("contention_grants");
    else begin
      for (int g = 0; g < 4; g++)
        chk($sformatf("contention_grant%0d", g), gq[g], STRICT ? 0 : (g % 2));
    end
    chk("contention_cnt0", o_pkt_cnt0, STRICT ? 4 : 2);
    chk("contention_cnt1", o_pkt_cnt1, STRICT ? 0 : 2);

    // Randomized traffic with varying load and back-pressure.
    flen = 0;
    for (int blk = 0; blk < 6; blk++) begin
      vpct[0] = int'($urandom_range(100, 20));
      vpct[1] = int'($urandom_range(100, 20));
      rpct = int'($urandom_range(100, 40));
      repeat (500) step();
    end

    // Counter wrap on port 0 (CNT_W = 8 in this bench).
    reset_all();
    vpct[0] = 100; vpct[1] = 0; rpct = 100; flen = 1;
    slen[0] = 1; slen[1] = 1;
    done = 0;
    for (int c = 0; c < 2500 && !done; c++) begin
      step();
      done = (mcnt[0] == 8'hFF);
    end
    if (!done) fail_bound("wrap_preload");
    step();
    chk("wrap_cnt0_ff", o_pkt_cnt0, 8'hFF);
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      done = (mcnt[0] == 8'h00);
    end
    if (!done) fail_bound("wrap_last_pkt");
    step();
    chk("wrap_cnt0_zero", o_pkt_cnt0, 8'h00);
    chk("wrap_cnt1", o_pkt_cnt1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
